// File: rtl/mips_tb_pkg.sv
// Shared types and defaults for the MIPS store monitor.
//   - mon_state_e : monitor FSM states
//   - store_rec_t : one logged store {addr, data}
//   - CHK_ADDR_DEF / CHK_DATA_DEF : default signature store address and value
package mips_tb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REC_W  = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] CHK_ADDR_DEF = 32'd84;
  localparam logic [DATA_W-1:0] CHK_DATA_DEF = 32'd7;

  typedef enum logic [2:0] {
    MON_IDLE,
    MON_RUN,
    MON_PASS,
    MON_FAIL,
    MON_TIMEOUT
  } mon_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } store_rec_t;

  // A verdict has been reached and is held until reset.
  function automatic logic is_terminal(input mon_state_e s);
    return (s == MON_PASS) || (s == MON_FAIL) || (s == MON_TIMEOUT);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and registered full/empty flags.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, wdata_i    write request and data
//   pop_i              read request (ignored when empty)
//   rvalid_o, rdata_o  popped entry, valid the cycle after an accepted pop
//   full_o, empty_o    occupancy flags
// A push while full is accepted only if a pop is accepted in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             rvalid_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Accept logic and next pointers; flags use the extra wrap bit.
  always_comb begin
    pop_ok  = pop_i && !empty_q;
    push_ok = push_i && (!full_q || pop_ok);
    wptr_d  = push_ok ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d  = pop_ok  ? (rptr_q + PW'(1)) : rptr_q;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  // Pointers, flags and read register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      rvalid_q <= pop_ok;
      if (pop_ok) begin
        rdata_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// File: rtl/mips_store_monitor.sv
// Store monitor for the single-cycle MIPS data-memory write bus.
// Logs every RUN-state store into a FIFO and issues a done/pass/fail/timeout
// verdict from the signature store at CHK_ADDR.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   memwrite, dataadr, writedata  CPU store bus
//   filt_base, filt_mask          log address filter (only with the macro)
//   rd_en                         pop one log entry
//   rd_valid, rd_addr, rd_data    popped entry, valid one cycle after pop
//   log_empty, log_full           log occupancy
//   overflow                      sticky: a store was dropped on a full log
//   done, pass, fail, timeout     registered verdict
// Optional feature macro: MIPS_STORE_MONITOR_ADDR_FILTER_EN (address filter
// on logging; the signature check always sees every store).
module mips_store_monitor
  import mips_tb_pkg::*;
#(
  parameter int unsigned       DEPTH       = 8,
  parameter logic [ADDR_W-1:0] CHK_ADDR    = CHK_ADDR_DEF,
  parameter logic [DATA_W-1:0] CHK_DATA    = CHK_DATA_DEF,
  parameter int unsigned       TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
`ifdef MIPS_STORE_MONITOR_ADDR_FILTER_EN
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] filt_mask,
`endif
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              log_empty,
  output logic              log_full,
  output logic              overflow,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;

  logic             filt_ok;
  logic             sig_hit;
  logic             log_req;
  store_rec_t       wr_rec;
  store_rec_t       rd_rec;
  logic             fifo_full, fifo_empty, fifo_rvalid;

  // Address filter on logging only.
`ifdef MIPS_STORE_MONITOR_ADDR_FILTER_EN
  assign filt_ok = ((dataadr & filt_mask) == filt_base);
`else
  assign filt_ok = 1'b1;
`endif

  assign sig_hit = memwrite && (dataadr == CHK_ADDR);

  // Next-state, counter, capture request and verdict flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    log_req     = 1'b0;
    wr_rec.addr = dataadr;
    wr_rec.data = writedata;

    case (state_q)
      // One dead cycle absorbs the CPU's first post-reset cycle.
      MON_IDLE: state_d = MON_RUN;
      MON_RUN: begin
        cnt_d   = cnt_q + CNT_W'(1);
        log_req = memwrite && filt_ok;
        // A pop while full frees the slot this push uses.
        if (log_req && fifo_full && !rd_en) begin
          ovf_d = 1'b1;
        end
        // Signature store wins over a timeout in the same cycle.
        if (sig_hit) begin
          state_d = (writedata == CHK_DATA) ? MON_PASS : MON_FAIL;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = MON_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase

    done_d = is_terminal(state_d);
    pass_d = (state_d == MON_PASS);
    fail_d = (state_d == MON_FAIL);
    tmo_d  = (state_d == MON_TIMEOUT);
  end

  // State and verdict registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MON_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  sync_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_log (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (log_req),
    .wdata_i (wr_rec),
    .pop_i   (rd_en),
    .rvalid_o(fifo_rvalid),
    .rdata_o (rd_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rd_valid  = fifo_rvalid;
  assign rd_addr   = rd_rec.addr;
  assign rd_data   = rd_rec.data;
  assign log_empty = fifo_empty;
  assign log_full  = fifo_full;
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_mips_store_monitor.sv
// Self-checking bench for mips_store_monitor (DEPTH=4, TIMEOUT_CYC=20).
// A queue-based reference model tracks log contents and the verdict.
module tb_mips_store_monitor;

  localparam int          DEPTH = 4;
  localparam int          TMO   = 20;
  localparam logic [31:0] SIG_A = 32'd84;
  localparam logic [31:0] SIG_D = 32'd7;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        log_empty;
  logic        log_full;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;

  mips_store_monitor #(
    .DEPTH      (DEPTH),
    .CHK_ADDR   (SIG_A),
    .CHK_DATA   (SIG_D),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .dataadr  (dataadr),
    .writedata(writedata),
`ifdef MIPS_STORE_MONITOR_ADDR_FILTER_EN
    .filt_base(32'h0),
    .filt_mask(32'h0),
`endif
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .log_empty(log_empty),
    .log_full (log_full),
    .overflow (overflow),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 running, 2 pass, 3 fail, 4 timeout.
  int          m_phase = 0;
  int          m_runs  = 0;
  logic [63:0] m_q[$];
  bit          m_ovf   = 0;
  bit          m_rv    = 0;
  logic [63:0] m_rec   = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit mw, input logic [31:0] a,
                            input logic [31:0] d, input bit rd);
    int pre;
    bit pop_ok;
    if (!rst_n) begin
      m_q.delete();
      m_phase = 0;
      m_runs  = 0;
      m_ovf   = 0;
      m_rv    = 0;
      return;
    end
    pre    = m_q.size();
    pop_ok = rd && (pre > 0);
    m_rv   = pop_ok;
    if (pop_ok) m_rec = m_q.pop_front();
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (mw) begin
        if (pre < DEPTH || pop_ok) m_q.push_back({a, d});
        else m_ovf = 1;
      end
      if (mw && a == SIG_A) m_phase = (d == SIG_D) ? 2 : 3;
      else if (m_runs == TMO - 1) m_phase = 4;
      else m_runs++;
    end
  endtask

  task automatic compare_all();
    chk("rd_valid", 64'(rd_valid), 64'(m_rv));
    if (m_rv) begin
      chk("rd_addr", 64'(rd_addr), 64'(m_rec[63:32]));
      chk("rd_data", 64'(rd_data), 64'(m_rec[31:0]));
    end
    chk("log_empty", 64'(log_empty), 64'(m_q.size() == 0));
    chk("log_full",  64'(log_full),  64'(m_q.size() == DEPTH));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("done",      64'(done),      64'(m_phase >= 2));
    chk("pass",      64'(pass),      64'(m_phase == 2));
    chk("fail",      64'(fail),      64'(m_phase == 3));
    chk("timeout",   64'(timeout),   64'(m_phase == 4));
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic cyc(input bit rst_n, input bit mw, input logic [31:0] a,
                     input logic [31:0] d, input bit rd);
    reset     = rst_n;
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    rd_en     = rd;
    @(posedge clk);
    model_step(rst_n, mw, a, d, rd);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    // Reset state.
    do_reset();
    chk("rst_empty", 64'(log_empty), 64'd1);
    chk("rst_done",  64'(done),      64'd0);

    // PASS: signature store after five quiet RUN cycles.
    idle(1);
    idle(5);
    cyc(1'b1, 1'b1, SIG_A, SIG_D, 1'b0);
    chk("pass_flag", 64'(pass), 64'd1);
    chk("pass_done", 64'(done), 64'd1);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("pass_log_addr", 64'(rd_addr), 64'd84);
    chk("pass_log_data", 64'(rd_data), 64'd7);
    idle(2);

    // FAIL, then a later good signature must not change the verdict.
    do_reset();
    idle(1);
    cyc(1'b1, 1'b1, 32'h20, 32'h3, 1'b0);
    cyc(1'b1, 1'b1, SIG_A, 32'd9, 1'b0);
    chk("fail_flag", 64'(fail), 64'd1);
    cyc(1'b1, 1'b1, SIG_A, SIG_D, 1'b0);
    idle(3);
    chk("fail_hold_pass", 64'(pass), 64'd0);
    chk("fail_hold_fail", 64'(fail), 64'd1);
    drain();

    // TIMEOUT after exactly TMO RUN cycles.
    do_reset();
    idle(1);
    idle(TMO - 1);
    chk("tmo_not_yet", 64'(timeout), 64'd0);
    idle(1);
    chk("tmo_flag", 64'(timeout), 64'd1);
    chk("tmo_empty", 64'(log_empty), 64'd1);
    idle(3);

    // Overflow: six stores into a four-entry log, then drain in order.
    do_reset();
    idle(1);
    for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b1, 32'(k * 16), 32'(k), 1'b0);
    chk("ovf_full", 64'(log_full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("ovf_pop_addr", 64'(rd_addr), 64'(k * 16));
    end
    chk("ovf_drained", 64'(log_empty), 64'd1);

    // Full log with simultaneous push and pop.
    do_reset();
    idle(1);
    for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b1, 32'(k * 16), 32'(k), 1'b0);
    cyc(1'b1, 1'b1, 32'h50, 32'h5, 1'b1);
    chk("pp_addr", 64'(rd_addr), 64'h10);
    chk("pp_full", 64'(log_full), 64'd1);
    chk("pp_ovf",  64'(overflow), 64'd0);
    drain();

    // Reset mid-run clears log, overflow and verdict; IDLE ignores a store.
    do_reset();
    idle(1);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b1, 32'(k * 16), 32'(k), 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("mid_empty", 64'(log_empty), 64'd1);
    chk("mid_ovf",   64'(overflow),  64'd0);
    chk("mid_done",  64'(done),      64'd0);
    cyc(1'b1, 1'b1, SIG_A, SIG_D, 1'b0);
    chk("idle_ignored", 64'(pass), 64'd0);
    cyc(1'b1, 1'b1, SIG_A, SIG_D, 1'b0);
    chk("rerun_pass", 64'(pass), 64'd1);
    drain();

    // Randomized episodes against the model.
    for (int e = 0; e < 40; e++) begin
      do_reset();
      for (int c = 0; c < 26; c++) begin
        bit          r_rst;
        bit          r_mw;
        bit          r_rd;
        logic [31:0] r_a;
        logic [31:0] r_d;
        r_rst = ($urandom_range(0, 59) != 0);
        r_mw  = ($urandom_range(0, 1) == 1);
        r_rd  = ($urandom_range(0, 9) < 4);
        r_a   = ($urandom_range(0, 15) == 0) ? SIG_A : 32'($urandom_range(0, 63) * 4);
        r_d   = ($urandom_range(0, 1) == 1) ? SIG_D : 32'($urandom);
        cyc(r_rst, r_mw, r_a, r_d, r_rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_store_monitor.md
Name: mips_store_monitor

Overview:
- Sits directly downstream of the single-cycle MIPS top, on its data-memory write bus (memwrite, dataadr, writedata).
- Captures every store into a small FIFO for bench readout.
- Decides pass/fail when the program's signature store (address CHK_ADDR) appears, and flags a timeout if that store never comes.
- Replaces the free-running fixed-delay stop with an explicit done/pass/fail verdict.

Parameters:
- DEPTH, 8: store-log FIFO entries; power of two, minimum 2.
- CHK_ADDR, 32'd84: signature store address.
- CHK_DATA, 32'd7: value expected at CHK_ADDR.
- TIMEOUT_CYC, 1000: RUN cycles allowed before timeout; minimum 2.

Ports:
- clk  in  1  processor clock, rising edge.
- reset  in  1  synchronous, active-low: reset==0 at a rising edge resets the block.
- memwrite  in  1  store strobe from the MIPS top.
- dataadr  in  32  store address.
- writedata  in  32  store data.
- rd_en  in  1  pop one log entry.
- rd_valid  out  1  rd_addr/rd_data valid this cycle.
- rd_addr  out  32  popped store address.
- rd_data  out  32  popped store data.
- log_empty  out  1  FIFO empty.
- log_full  out  1  FIFO full.
- overflow  out  1  sticky: a store was dropped because the FIFO was full.
- done  out  1  verdict reached.
- pass  out  1  signature matched.
- fail  out  1  signature mismatched.
- timeout  out  1  no signature within TIMEOUT_CYC.

Behaviour:
- Reset: all outputs 0 except log_empty=1; FIFO pointers 0; cycle counter 0; FSM in IDLE.
- FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT.
- IDLE: lasts exactly one cycle after reset deasserts, then goes to RUN. Stores are ignored in IDLE, covering the CPU's first post-reset cycle.
- RUN, counting: the cycle counter increments every cycle. Counter width is $clog2(TIMEOUT_CYC+1).
- RUN, capture: on memwrite=1, push {dataadr, writedata}. If the FIFO is full and there is no simultaneous pop, drop the store and set overflow.
- RUN, signature check (same cycle as capture):
  - memwrite && dataadr==CHK_ADDR && writedata==CHK_DATA → PASS.
  - memwrite && dataadr==CHK_ADDR && writedata!=CHK_DATA → FAIL.
  - The signature store itself is still logged.
- RUN, timeout: counter == TIMEOUT_CYC-1 with no signature store this cycle → TIMEOUT. A signature store in that same cycle takes priority and gives PASS or FAIL.
- Terminal states (PASS, FAIL, TIMEOUT):
  - Held until reset.
  - done=1 plus exactly one of pass/fail/timeout, all registered (asserted the cycle after the deciding edge).
  - Capture stops; the counter freezes; the FIFO stays readable.
- Read side:
  - rd_en with FIFO non-empty pops; rd_valid=1 with registered data on the next cycle only.
  - rd_en when empty is ignored; rd_valid=0.
  - Push and pop in the same cycle are both honoured, including when full. Occupancy is unchanged.
- Pointers: log2(DEPTH)+1 bits each, wrapping naturally. full/empty come from MSB compare.
- overflow is cleared only by reset.
- Reset mid-run: everything returns to reset values at that edge. Log contents are discarded.

Optional Feature:
- Macro: MIPS_STORE_MONITOR_ADDR_FILTER_EN.
- Defined: adds input ports filt_base (32) and filt_mask (32). Only stores where (dataadr & filt_mask)==filt_base are logged. The signature check is unaffected by the filter.
- Undefined: the ports are absent and every RUN-state store is logged.

Decomposition:
- Shared package mips_tb_pkg holds:
  - monitor state enum (IDLE/RUN/PASS/FAIL/TIMEOUT);
  - default CHK_ADDR/CHK_DATA localparams;
  - the 64-bit store-record typedef {addr, data}.
- One sub-module: sync_fifo, parameterised on width and depth, registered read, providing full/empty. Instantiated with width 64, depth DEPTH.

Test Plan:
- Store (84,7) at cycle 5 of RUN → PASS: done=1, pass=1 one cycle later; log holds (84,7); fail=timeout=0.
- Store (84,9) → FAIL: done=1, fail=1; a subsequent store (84,7) leaves state and outputs unchanged.
- No signature store, TIMEOUT_CYC=20 → timeout=1 and done=1 on the cycle after RUN counter 19; FIFO log unchanged.
- DEPTH=4, six stores (0x10..0x60, data 1..6) with no reads → log_full=1, overflow=1; pops return 0x10..0x40 in order, then log_empty=1.
- Full FIFO with memwrite and rd_en asserted together → oldest entry popped, new store accepted, overflow stays 0, log_full stays 1.
- reset=0 while in RUN with 3 entries logged → next cycle log_empty=1, done=0, overflow=0, state IDLE; the monitor then re-runs and passes on (84,7).
